param_fifo: RTL and testbench

//  Parametrised single-clock FIFO; next generation of the team's 8x32 queue.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_mem.sv | 33 +++
 rtl/param_fifo.sv | 148 ++++++++++++++
 tb/tb_param_fifo.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared constants and helper function for the parametrised FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int c_DEFAULT_DWIDTH = 32;
    localparam int c_DEFAULT_DEPTH  = 8;

    // Ceiling log2, evaluated at elaboration time for pointer widths.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : fifo_mem
// Brief    : DEPTH x DWIDTH storage array, synchronous write, async read.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DWIDTH = c_DEFAULT_DWIDTH,
    parameter int AW     = clog2(c_DEFAULT_DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DWIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DWIDTH-1:0] o_rd_data
);

    // Storage is intentionally left unreset; occupancy tracking guards reads.
    logic [DWIDTH-1:0] r_mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : fifo_mem
`default_nettype wire

// File: rtl/param_fifo.sv
`default_nettype none
// ============================================================================
// Module   : param_fifo
// Brief    : Parametrised single-clock FIFO with FWFT/registered read,
//            programmable almost flags and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
module param_fifo
    import fifo_pkg::*;
#(
    parameter int DWIDTH        = c_DEFAULT_DWIDTH,
    parameter int DEPTH         = c_DEFAULT_DEPTH,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    enq,
    input  logic [DWIDTH-1:0]       din,
    input  logic                    deq,
    output logic [DWIDTH-1:0]       dout,
    output logic                    dout_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   count,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    clr_err
);

    localparam int                c_AW         = clog2(DEPTH);
    localparam logic [c_AW:0]     c_DEPTH_CNT  = DEPTH[c_AW:0];
    localparam logic [c_AW:0]     c_AFULL_CNT  = AFULL_THRESH[c_AW:0];
    localparam logic [c_AW:0]     c_AEMPTY_CNT = AEMPTY_THRESH[c_AW:0];

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("param_fifo: DEPTH must be a power of two >= 2");
    end
    if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_chk_afull
        $error("param_fifo: AFULL_THRESH out of range 1..DEPTH");
    end
    if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH > DEPTH - 1)) begin : g_chk_aempty
        $error("param_fifo: AEMPTY_THRESH out of range 0..DEPTH-1");
    end
    if (DWIDTH < 1) begin : g_chk_dwidth
        $error("param_fifo: DWIDTH must be >= 1");
    end

    logic [c_AW:0]       r_wr_ptr;
    logic [c_AW:0]       r_rd_ptr;
    logic                r_overflow;
    logic                r_underflow;
    logic [c_AW:0]       w_count;
    logic                w_full;
    logic                w_empty;
    logic                w_deq_ok;
    logic                w_enq_ok;
    logic [DWIDTH-1:0]   w_rd_data;

    // The wrap bit makes pointer difference span 0..DEPTH, so occupancy
    // tracks enq_ok - deq_ok exactly without a separate counter.
    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_full   = (w_count == c_DEPTH_CNT);
    assign w_empty  = (w_count == '0);
    assign w_deq_ok = deq & ~w_empty;
    assign w_enq_ok = enq & (~w_full | w_deq_ok);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_enq_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // A fresh error in the same cycle as clr_err takes priority.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (enq & w_full & ~w_deq_ok) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (deq & w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    fifo_mem #(
        .DWIDTH (DWIDTH),
        .AW     (c_AW)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_enq_ok),
        .i_wr_addr (r_wr_ptr[c_AW-1:0]),
        .i_wr_data (din),
        .i_rd_addr (r_rd_ptr[c_AW-1:0]),
        .o_rd_data (w_rd_data)
    );

    if (FWFT != 0) begin : g_fwft
        assign dout       = w_empty ? '0 : w_rd_data;
        assign dout_valid = ~w_empty;
    end else begin : g_reg_read
        logic [DWIDTH-1:0] r_dout;
        logic              r_dout_valid;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_dout       <= '0;
                r_dout_valid <= 1'b0;
            end else begin
                r_dout_valid <= w_deq_ok;
                if (w_deq_ok) begin
                    r_dout <= w_rd_data;
                end
            end
        end

        assign dout       = r_dout;
        assign dout_valid = r_dout_valid;
    end

    assign count        = w_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (w_count >= c_AFULL_CNT);
    assign almost_empty = (w_count <= c_AEMPTY_CNT);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule : param_fifo
`default_nettype wire

// File: tb/tb_param_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_fifo
// Brief    : Directed self-checking bench for param_fifo (FWFT and registered).
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_fifo;

    logic        clk;
    logic        rstn;

    logic        enq, deq, clr_err;
    logic [31:0] din;
    logic [31:0] dout;
    logic        dout_valid, full, empty, almost_full, almost_empty;
    logic [3:0]  count;
    logic        overflow, underflow;

    logic        enq0, deq0, clr_err0;
    logic [31:0] din0;
    logic [31:0] dout0;
    logic        dout_valid0, full0, empty0, almost_full0, almost_empty0;
    logic [3:0]  count0;
    logic        overflow0, underflow0;

    int n_checks;
    int n_fail;

    param_fifo #(.FWFT(1)) u_dut (
        .clk(clk), .rstn(rstn), .enq(enq), .din(din), .deq(deq),
        .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    param_fifo #(.FWFT(0)) u_dut_reg (
        .clk(clk), .rstn(rstn), .enq(enq0), .din(din0), .deq(deq0),
        .dout(dout0), .dout_valid(dout_valid0), .full(full0), .empty(empty0),
        .almost_full(almost_full0), .almost_empty(almost_empty0), .count(count0),
        .overflow(overflow0), .underflow(underflow0), .clr_err(clr_err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        enq = 0; deq = 0; clr_err = 0; din = '0;
        enq0 = 0; deq0 = 0; clr_err0 = 0; din0 = '0;
        #23;
        n_checks++;
        if ({count, empty, almost_empty, full, almost_full} !== {4'd0, 4'b1100}) begin
            n_fail++;
            $display("FAIL reset_flags: got count=%0d e=%b ae=%b f=%b af=%b, want 0 1 1 0 0",
                     count, empty, almost_empty, full, almost_full);
        end
        n_checks++;
        if ({dout, dout_valid, overflow, underflow} !== {32'h0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_out: got dout=%h v=%b ov=%b un=%b, want 0 0 0 0",
                     dout, dout_valid, overflow, underflow);
        end
        n_checks++;
        if ({dout0, dout_valid0, count0} !== {32'h0, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_reg: got dout=%h v=%b count=%0d, want 0 0 0",
                     dout0, dout_valid0, count0);
        end
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 8; i++) begin
            enq = 1; din = 32'h10 + i;
            tick();
            n_checks++;
            if (count !== 4'(i + 1) || full !== (i == 7) || almost_full !== (i + 1 >= 6) ||
                almost_empty !== (i + 1 <= 2) || empty !== 1'b0 || dout !== 32'h10) begin
                n_fail++;
                $display("FAIL fill_%0d: got count=%0d f=%b af=%b ae=%b e=%b dout=%h, want %0d %b %b %b 0 10",
                         i, count, full, almost_full, almost_empty, empty, dout,
                         i + 1, i == 7, i + 1 >= 6, i + 1 <= 2);
            end
        end
        enq = 0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (dout !== 32'h10 + i || dout_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_%0d: got dout=%h v=%b, want %h 1", i, dout, dout_valid, 32'h10 + i);
            end
            deq = 1;
            tick();
        end
        deq = 0;
        n_checks++;
        if (empty !== 1'b1 || count !== 4'd0 || dout_valid !== 1'b0 || dout !== 32'h0) begin
            n_fail++;
            $display("FAIL drained: got e=%b count=%0d v=%b dout=%h, want 1 0 0 0",
                     empty, count, dout_valid, dout);
        end
    endtask

    task automatic test_full_enq_deq();
        for (int i = 0; i < 8; i++) begin
            enq = 1; din = 32'h20 + i;
            tick();
        end
        enq = 1; deq = 1; din = 32'hAA;
        tick();
        enq = 0; deq = 0;
        n_checks++;
        if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b0 || dout !== 32'h21) begin
            n_fail++;
            $display("FAIL full_simul: got count=%0d f=%b ov=%b dout=%h, want 8 1 0 21",
                     count, full, overflow, dout);
        end
        for (int i = 0; i < 8; i++) begin
            logic [31:0] exp;
            exp = (i == 7) ? 32'hAA : 32'h21 + i;
            n_checks++;
            if (dout !== exp) begin
                n_fail++;
                $display("FAIL full_simul_out_%0d: got %h, want %h", i, dout, exp);
            end
            deq = 1;
            tick();
        end
        deq = 0;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) begin
            enq = 1; din = 32'h30 + i;
            tick();
        end
        din = 32'hBB;
        tick();
        enq = 0;
        n_checks++;
        if (overflow !== 1'b1 || count !== 4'd8 || dout !== 32'h30) begin
            n_fail++;
            $display("FAIL overflow_set: got ov=%b count=%0d dout=%h, want 1 8 30",
                     overflow, count, dout);
        end
        clr_err = 1;
        tick();
        clr_err = 0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_clr: got %b, want 0", overflow);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (dout !== 32'h30 + i) begin
                n_fail++;
                $display("FAIL overflow_out_%0d: got %h, want %h", i, dout, 32'h30 + i);
            end
            deq = 1;
            tick();
        end
        deq = 0;
    endtask

    task automatic test_underflow();
        deq = 1;
        tick();
        deq = 0;
        n_checks++;
        if (underflow !== 1'b1 || count !== 4'd0 || empty !== 1'b1 || dout !== 32'h0) begin
            n_fail++;
            $display("FAIL underflow_set: got un=%b count=%0d e=%b dout=%h, want 1 0 1 0",
                     underflow, count, empty, dout);
        end
        enq = 1; deq = 1; din = 32'h5;
        tick();
        enq = 0; deq = 0;
        n_checks++;
        if (count !== 4'd1 || underflow !== 1'b1 || dout !== 32'h5 || dout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_simul: got count=%0d un=%b dout=%h v=%b, want 1 1 5 1",
                     count, underflow, dout, dout_valid);
        end
        deq = 1;
        tick();
        clr_err = 1;
        tick();
        deq = 0;
        n_checks++;
        if (underflow !== 1'b1 || count !== 4'd0) begin
            n_fail++;
            $display("FAIL underflow_wins_clr: got un=%b count=%0d, want 1 0", underflow, count);
        end
        tick();
        clr_err = 0;
        n_checks++;
        if (underflow !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_clr: got un=%b ov=%b, want 0 0", underflow, overflow);
        end
    endtask

    task automatic test_registered_read();
        enq0 = 1; din0 = 32'h1;
        tick();
        din0 = 32'h2;
        tick();
        enq0 = 0;
        n_checks++;
        if (dout_valid0 !== 1'b0 || dout0 !== 32'h0 || count0 !== 4'd2) begin
            n_fail++;
            $display("FAIL reg_prefetch: got v=%b dout=%h count=%0d, want 0 0 2",
                     dout_valid0, dout0, count0);
        end
        deq0 = 1;
        tick();
        deq0 = 0;
        n_checks++;
        if (dout0 !== 32'h1 || dout_valid0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reg_pop1: got dout=%h v=%b, want 1 1", dout0, dout_valid0);
        end
        tick();
        n_checks++;
        if (dout0 !== 32'h1 || dout_valid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reg_pulse: got dout=%h v=%b, want 1 0", dout0, dout_valid0);
        end
        deq0 = 1;
        tick();
        n_checks++;
        if (dout0 !== 32'h2 || dout_valid0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reg_pop2: got dout=%h v=%b, want 2 1", dout0, dout_valid0);
        end
        tick();
        deq0 = 0;
        n_checks++;
        if (dout0 !== 32'h2 || dout_valid0 !== 1'b0 || underflow0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reg_rejected_pop: got dout=%h v=%b un=%b, want 2 0 1",
                     dout0, dout_valid0, underflow0);
        end
        enq0 = 1; din0 = 32'h100;
        tick();
        for (int k = 1; k <= 20; k++) begin
            din0 = 32'h100 + k; deq0 = 1;
            tick();
            n_checks++;
            if (dout0 !== 32'h100 + k - 1 || dout_valid0 !== 1'b1 || count0 !== 4'd1) begin
                n_fail++;
                $display("FAIL reg_stream_%0d: got dout=%h v=%b count=%0d, want %h 1 1",
                         k, dout0, dout_valid0, count0, 32'h100 + k - 1);
            end
        end
        enq0 = 0;
        tick();
        deq0 = 0;
        n_checks++;
        if (dout0 !== 32'h114 || count0 !== 4'd0 || empty0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reg_stream_end: got dout=%h count=%0d e=%b, want 114 0 1",
                     dout0, count0, empty0);
        end
    endtask

    task automatic test_async_reset();
        deq = 1;
        tick();
        deq = 0;
        for (int i = 0; i < 5; i++) begin
            enq = 1; din = 32'h40 + i;
            tick();
        end
        enq = 0;
        n_checks++;
        if (count !== 4'd5 || underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got count=%0d un=%b, want 5 1", count, underflow);
        end
        #2;
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({count, empty, almost_empty, full, almost_full, dout, dout_valid, overflow, underflow}
            !== {4'd0, 4'b1100, 32'h0, 3'b000}) begin
            n_fail++;
            $display("FAIL async_reset: got count=%0d e=%b ae=%b f=%b af=%b dout=%h v=%b ov=%b un=%b",
                     count, empty, almost_empty, full, almost_full, dout, dout_valid, overflow, underflow);
        end
        rstn = 1'b1;
        enq = 1; din = 32'h77;
        tick();
        enq = 0;
        n_checks++;
        if (count !== 4'd1 || dout !== 32'h77 || dout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_push: got count=%0d dout=%h v=%b, want 1 77 1",
                     count, dout, dout_valid);
        end
        deq = 1;
        tick();
        deq = 0;
        n_checks++;
        if (count !== 4'd0 || empty !== 1'b1 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_pop: got count=%0d e=%b un=%b, want 0 1 0",
                     count, empty, underflow);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_fill_drain();
        test_full_enq_deq();
        test_overflow();
        test_underflow();
        test_registered_read();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_param_fifo
`default_nettype wire
